// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver (start / DATA_BITS data LSB first /
// parity / stop), oversampled by an external baud tick.
//
// The line is brought into the clk domain by a 2-flop synchronizer. A
// synchronized falling edge while idle opens a frame. Each bit is sampled at
// its centre, counted in clk_tick pulses. The completed frame is presented as
// {parity_bit, data} together with a one-cycle valid strobe.
//
// Optional build macro:
//   UART_RX_MAJORITY_VOTE_EN  -- every bit decision (start validation included)
//                                is the 2-of-3 majority of three consecutive
//                                tick samples around the bit centre, instead
//                                of a single centre sample.
//
// Parameters:
//   OVERSAMPLE  clk_tick pulses per bit period (even, >= 4)
//   DATA_BITS   data bits per frame
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active low
//   clk_tick       one-clk-wide oversample strobe, synchronous to clk
//   rx_serial      asynchronous serial line, idle high
//   rx_data_byte   {received parity bit, data[DATA_BITS-1:0]}, held until
//                  the next completed frame
//   rx_data_avail  one-cycle strobe: rx_data_byte / error / frame_err valid
//   error          parity error for the last frame
//   frame_err      stop bit sampled low for the last frame
//   rx_active      high from start-edge detect until return to idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_tick,
    input  logic               rx_serial,
    output logic [DATA_BITS:0] rx_data_byte,
    output logic               rx_data_avail,
    output logic               error,
    output logic               frame_err,
    output logic               rx_active
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // Frame FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Tick count at which the bit decision is taken. With majority voting the
    // decision lands on the third sample (one tick past centre); the start
    // decision therefore moves one tick later, which re-references all later
    // bit periods to centre+1 and keeps the spacing at OVERSAMPLE ticks.
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] START_LAST = CW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [CW-1:0] BIT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST   = BW'(DATA_BITS - 1);

    // -------------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // -------------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       prev_q;
    logic       line;
    logic       fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_serial};
            prev_q <= sync_q[1];
        end
    end

    assign line = sync_q[1];
    assign fall = prev_q & ~line;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [2:0]           state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [BW-1:0]        idx_q,    idx_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 par_q,    par_d;
    logic                 stop_q,   stop_d;
    logic [DATA_BITS:0]   byte_q,   byte_d;
    logic                 err_q,    err_d;
    logic                 ferr_q,   ferr_d;
    logic                 avail_q,  avail_d;
    logic                 active_q, active_d;

    // Value of the bit being decided on this tick.
    logic bit_val;

    // -------------------------------------------------------------------------
    // Bit value: majority of three samples, or the centre sample alone
    // -------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [CW-1:0] last_cnt;
    logic [1:0]    vote_q, vote_d;

    assign last_cnt = (state_q == S_START) ? START_LAST : BIT_LAST;

    // The first two samples are stored; the third is the live line value on
    // the decision tick.
    always_comb begin
        vote_d = vote_q;
        if (clk_tick && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            if (cnt_q == last_cnt - CW'(2)) vote_d[0] = line;
            if (cnt_q == last_cnt - CW'(1)) vote_d[1] = line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vote_q <= 2'b11;
        else      vote_q <= vote_d;
    end

    assign bit_val = (vote_q[0] & vote_q[1]) |
                     (vote_q[0] & line)      |
                     (vote_q[1] & line);
`else
    assign bit_val = line;
`endif

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        par_d    = par_q;
        stop_d   = stop_q;
        byte_d   = byte_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        avail_d  = 1'b0;
        active_d = active_q;

        case (state_q)
            S_IDLE: begin
                // Edge detect runs every clk; a tick is not needed to open
                // a frame.
                if (fall) begin
                    state_d  = S_START;
                    cnt_d    = '0;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (clk_tick) begin
                    if (cnt_q == START_LAST) begin
                        cnt_d = '0;
                        if (bit_val) begin
                            // Line back high at start centre: glitch, not a
                            // frame. Held outputs stay untouched.
                            state_d  = S_IDLE;
                            active_d = 1'b0;
                        end else begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DATA: begin
                if (clk_tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d         = '0;
                        data_d[idx_q] = bit_val;
                        if (idx_q == IDX_LAST) state_d = S_PARITY;
                        else                   idx_d   = idx_q + BW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (clk_tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        par_d   = bit_val;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_STOP: begin
                // Leaving at the stop-bit centre gives half a bit of margin to
                // catch a back-to-back start edge.
                if (clk_tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        stop_d  = bit_val;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DONE: begin
                byte_d   = {par_q, data_q};
                err_d    = (^data_q) ^ par_q ^ PAR_ODD;
                ferr_d   = ~stop_q;
                avail_d  = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            byte_q   <= '0;
            err_q    <= 1'b0;
            ferr_q   <= 1'b0;
            avail_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            byte_q   <= byte_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            avail_q  <= avail_d;
            active_q <= active_d;
        end
    end

    assign rx_data_byte  = byte_q;
    assign rx_data_avail = avail_q;
    assign error         = err_q;
    assign frame_err     = ferr_q;
    assign rx_active     = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx.
// The driver serializes frames onto rx_serial and pushes the expected result
// (derived from the frame contents) into a queue; a monitor pops and compares
// on every rx_data_avail strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_tick;
    logic       rx_serial;
    logic [8:0] rx_data_byte;
    logic       rx_data_avail;
    logic       error;
    logic       frame_err;
    logic       rx_active;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_tick      (clk_tick),
        .rx_serial     (rx_serial),
        .rx_data_byte  (rx_data_byte),
        .rx_data_avail (rx_data_avail),
        .error         (error),
        .frame_err     (frame_err),
        .rx_active     (rx_active)
    );

    always #5 clk = ~clk;

    // One-clk tick every TICK_DIV clocks, changed on the falling edge.
    initial begin
        clk_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            clk_tick = 1'b1;
            @(negedge clk);
            clk_tick = 1'b0;
        end
    end

    typedef struct {
        logic [8:0] b;
        logic       err;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_strobe = 0;
    int   n_sent   = 0;

    // Expected held output values (from the model, not the DUT).
    logic [8:0] last_b    = '0;
    logic       last_err  = 1'b0;
    logic       last_ferr = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the frame's fields rearranged; error is the parity of the
    // count of ones over data plus parity bit (even parity).
    function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.b    = {par, d};
        e.err  = ((($countones(d) + int'(par)) % 2) != 0);
        e.ferr = !stop;
        return e;
    endfunction

    // Monitor: every strobe must match the oldest outstanding frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rx_data_avail) begin
                n_strobe++;
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("rx_data_byte", 32'(rx_data_byte), 32'(e.b));
                    check("error",        32'(error),        32'(e.err));
                    check("frame_err",    32'(frame_err),    32'(e.ferr));
                    last_b    = e.b;
                    last_err  = e.err;
                    last_ferr = e.ferr;
                end
            end
        end
    end

    task automatic drive(input logic v, input int nclk);
        rx_serial = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        sb.push_back(model(d, par, stop));
        n_sent++;
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive(d[i], BIT_CLKS / 2);
            if (i == 0) check("rx_active_mid", 32'(rx_active), 32'(1));
            repeat (BIT_CLKS / 2) @(negedge clk);
        end
        drive(par, BIT_CLKS);
        drive(stop, BIT_CLKS - 1);
        // Frame finished at stop centre: strobe already seen, receiver idle.
        check("rx_active_end", 32'(rx_active), 32'(0));
        check("strobe_seen",   32'(sb.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         gap;

        rst       = 1'b0;
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_byte",   32'(rx_data_byte),  32'(0));
        check("reset_avail",  32'(rx_data_avail), 32'(0));
        check("reset_error",  32'(error),         32'(0));
        check("reset_ferr",   32'(frame_err),     32'(0));
        check("reset_active", 32'(rx_active),     32'(0));
        rst = 1'b1;
        drive(1'b1, BIT_CLKS);

        // Basic frame
        send_frame(8'h54, 1'b1, 1'b1);
        drive(1'b1, BIT_CLKS);

        // Back-to-back, no idle gap
        send_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        drive(1'b1, BIT_CLKS);

        // Parity error
        send_frame(8'h54, 1'b0, 1'b1);
        drive(1'b1, BIT_CLKS);

        // Low stop bit, held low (break), then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 3 * BIT_CLKS);
        drive(1'b1, BIT_CLKS);
        send_frame(8'h81, 1'b0, 1'b1);
        drive(1'b1, BIT_CLKS);

        // Glitch: 4 ticks low
        drive(1'b0, 4 * TICK_DIV);
        check("glitch_active", 32'(rx_active), 32'(1));
        drive(1'b1, BIT_CLKS);
        check("glitch_idle",  32'(rx_active),    32'(0));
        check("glitch_byte",  32'(rx_data_byte), 32'(last_b));
        check("glitch_error", 32'(error),        32'(last_err));
        check("glitch_ferr",  32'(frame_err),    32'(last_ferr));

        // Reset in the middle of data bit 3
        d = 8'h54;
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive(d[i], BIT_CLKS);
        drive(d[3], BIT_CLKS / 2);
        check("pre_reset_active", 32'(rx_active), 32'(1));
        rst = 1'b0;
        #1;
        check("midrst_byte",   32'(rx_data_byte),  32'(0));
        check("midrst_avail",  32'(rx_data_avail), 32'(0));
        check("midrst_error",  32'(error),         32'(0));
        check("midrst_ferr",   32'(frame_err),     32'(0));
        check("midrst_active", 32'(rx_active),     32'(0));
        last_b    = '0;
        last_err  = 1'b0;
        last_ferr = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, BIT_CLKS);
        send_frame(8'h54, 1'b1, 1'b1);
        drive(1'b1, BIT_CLKS);

        // Randomized frames: bad parity and low stop bits mixed in
        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            par  = ^d;
            if ($urandom_range(3) == 0) par = ~par;
            stop = ($urandom_range(7) != 0);
            send_frame(d, par, stop);
            gap = stop ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
            if (gap > 0) drive(1'b1, gap * BIT_CLKS);
        end

        drive(1'b1, BIT_CLKS);
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'(0));
        check("strobe_count",  32'(n_strobe),  32'(n_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
